// File: rtl/cdc_pkg.sv
// Shared definitions for the four-phase CDC handshake transmitter.
// Holds the FSM state encoding, the default synchronizer depth and a counter-width helper.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } cdc_state_t;

  localparam int CDC_DEF_STAGES = 2;

  // Width of a counter that must be able to reach t-1.
  function automatic int cnt_width(input int t);
    return $clog2(t) + 1;
  endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// NSTAGES-deep single-bit synchronizer for the acknowledge coming from the destination domain.
// Every flop clears on asynchronous active-high reset.
module cdc_ack_sync #(
  parameter int NSTAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [NSTAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NSTAGES-2:0], d};
    end
  end

  assign q = sync_q[NSTAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a four-phase req/ack crossing: accepts one payload, holds it on xfer_data and
// runs req up/ack up/req down/ack down. Optional watchdog compiled in by CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NSTAGES   = CDC_DEF_STAGES,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 xfer_req,
  output logic [DATAWIDTH-1:0] xfer_data,
  input  logic                 xfer_ack,
  output logic                 busy,
  output logic                 timeout
);

  // Upstream handshake: a payload transfers on a rising edge where in_valid && in_ready;
  // in_ready depends on state only, so in_valid may wait on it but not the other way round.

  cdc_state_t state_q, state_d;
  logic       ack_s;
  logic       req_d;
  logic       load_d;

  cdc_ack_sync #(
    .NSTAGES (NSTAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (xfer_ack),
    .q     (ack_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
    end else begin
      state_q  <= state_d;
      xfer_req <= req_d;
      if (load_d) begin
        xfer_data <= in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = xfer_req;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A stale ack_s here is ignored; REQ still waits for its own ack_s.
        if (in_valid) begin
          state_d = REQ;
          req_d   = 1'b1;
          load_d  = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = RELEASE;
          req_d   = 1'b0;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] to_cnt;
  logic          timeout_q;

  // Counter restarts on every state change and saturates once it has flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        to_cnt <= '0;
      end else if (busy && (to_cnt != CNT_LAST)) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (busy && (to_cnt == CNT_LAST)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx (NSTAGES=2, TIMEOUT=16): a vector table with a hand-driven ack,
// then sequences for latency, back-to-back transfers, mid-handshake reset, timeout and stale ack.
module tb_cdc_hs_tx;

  localparam int DW = 8;
  localparam int NS = 2;
  localparam int TO = 16;
`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack;
  logic          busy;
  logic          timeout;

  logic man_ack = 1'b0;
  logic resp_ack = 1'b0;
  logic resp_en = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];

  assign xfer_ack = resp_en ? resp_ack : man_ack;

  cdc_hs_tx #(
    .DATAWIDTH (DW),
    .NSTAGES   (NS),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .xfer_req  (xfer_req),
    .xfer_data (xfer_data),
    .xfer_ack  (xfer_ack),
    .busy      (busy),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Destination model: echoes req on the falling edge, half a cycle after it changes.
  initial begin
    forever begin
      @(negedge clk);
      resp_ack = xfer_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    man_ack  = 1'b0;
    resp_en  = 1'b0;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          req;
    logic [DW-1:0] data;
    logic          rdy;
    logic          bsy;
  } vec_t;

  vec_t vt[18];

  initial begin
    int            n;
    int            cyc;
    int            k;
    int            got;
    int            last_acc;
    logic          acc;
    logic          prev_req;
    logic          data_ok;
    logic [DW-1:0] vals[3];
    logic [DW-1:0] exp_d;

    // inputs {valid, data, ack} -> outputs after the edge {req, data, ready, busy}
    vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vt[17] = '{1'b0, 8'h11, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};

    // Reset state before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("reset_state", {xfer_req, in_ready, busy, timeout, xfer_data}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    repeat (2) tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      in_valid = vt[i].v;
      in_data  = vt[i].d;
      man_ack  = vt[i].a;
      tick();
      check($sformatf("vec%0d", i), {xfer_req, in_ready, busy, xfer_data},
            {vt[i].req, vt[i].rdy, vt[i].bsy, vt[i].data});
    end
    in_valid = 1'b0;

    // Latency with the responder: req falls 3 cycles after accept, ready returns after 6.
    resp_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    check("accept_a5", {xfer_req, in_ready, busy, xfer_data}, {1'b1, 1'b0, 1'b1, 8'hA5});
    in_valid = 1'b0;
    in_data  = 8'hFF;
    n = 0;
    data_ok = 1'b1;
    while (xfer_req && n < 20) begin
      tick();
      n++;
      if (xfer_data !== 8'hA5) data_ok = 1'b0;
    end
    check("req_fall_cycles", n, 3);
    while (!in_ready && n < 30) begin
      tick();
      n++;
      if (xfer_data !== 8'hA5) data_ok = 1'b0;
    end
    check("ready_cycles", n, 6);
    check("data_hold_a5", data_ok, 1'b1);

    // Back-to-back transfers with in_valid held high; in_data scrambled while busy.
    vals[0] = 8'h01;
    vals[1] = 8'h02;
    vals[2] = 8'h03;
    for (int i = 0; i < 3; i++) exp_q.push_back(vals[i]);
    k = 0;
    got = 0;
    cyc = 0;
    last_acc = 0;
    data_ok = 1'b1;
    exp_d = xfer_data;
    while (got < 3 && cyc < 200) begin
      in_valid = (k < 3);
      if (in_ready && k < 3) in_data = vals[k];
      else in_data = 8'($urandom_range(16, 255));
      acc = in_ready && (k < 3);
      prev_req = xfer_req;
      tick();
      cyc++;
      if (acc) begin
        if (k > 0) check($sformatf("spacing%0d", k), cyc - last_acc, 7);
        last_acc = cyc;
        k++;
      end
      if (xfer_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("extra_xfer", xfer_data, 8'h00);
        end else begin
          exp_d = exp_q.pop_front();
          check($sformatf("xfer%0d", got), xfer_data, exp_d);
        end
        got++;
      end else if (xfer_data !== exp_d) begin
        data_ok = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", got, 3);
    check("b2b_queue_empty", exp_q.size(), 0);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
      if (xfer_data !== 8'h03) data_ok = 1'b0;
    end
    check("b2b_idle", in_ready, 1'b1);
    check("b2b_data_hold", data_ok, 1'b1);

    // Reset while in REQ clears outputs without a clock edge.
    resp_en  = 1'b0;
    man_ack  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_reset_req", {xfer_req, busy}, {1'b1, 1'b1});
    reset = 1'b1;
    #1;
    check("mid_reset", {xfer_req, busy, in_ready, xfer_data}, {1'b0, 1'b0, 1'b1, 8'h00});
    tick();
    reset = 1'b0;
    tick();
    check("post_reset", {in_ready, busy, xfer_req}, {1'b1, 1'b0, 1'b0});

    // Timeout watchdog with ack held low, then a late ack completes normally.
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    check("timeout_early", timeout, 1'b0);
    tick();
    check("timeout_set", timeout, TO_EN);
    repeat (5) tick();
    check("timeout_sticky", {timeout, xfer_req, busy}, {TO_EN, 1'b1, 1'b1});
    man_ack = 1'b1;
    n = 0;
    while (xfer_req && n < 20) begin
      tick();
      n++;
    end
    check("late_ack_req_fall", n, 3);
    man_ack = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("late_ack_idle", {in_ready, xfer_data, timeout}, {1'b1, 8'h77, TO_EN});
    do_reset();
    check("timeout_cleared", timeout, 1'b0);

    // Stale ack in IDLE: ignored, then REQ sees the already-synchronized ack.
    man_ack = 1'b1;
    repeat (4) tick();
    check("stale_ack_idle", {in_ready, busy, xfer_req}, {1'b1, 1'b0, 1'b0});
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    check("stale_accept", {xfer_req, xfer_data}, {1'b1, 8'hC3});
    tick();
    check("stale_req_fall", {xfer_req, busy}, {1'b0, 1'b1});
    man_ack = 1'b0;
    repeat (2) tick();
    check("stale_release_hold", busy, 1'b1);
    tick();
    check("stale_idle", {in_ready, busy, xfer_data}, {1'b1, 1'b0, 8'hC3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 Parameter DATAWIDTH, default 8: width of the payload carried across the crossing.
REQ-002 Parameter NSTAGES, default 2 (legal >= 2): flop count of the ack synchronizer.
REQ-003 Parameter TIMEOUT, default 1024: cycles a handshake phase may wait before timeout is flagged.
REQ-004 clk  input  1  sole clock (source domain); one clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, asynchronous assert, active-high.
REQ-006 in_valid  input  1  payload offered this cycle.
REQ-007 in_ready  output  1  block accepts payload this cycle.
REQ-008 in_data  input  DATAWIDTH  payload.
REQ-009 xfer_req  output  1  four-phase request toward the destination domain; registered.
REQ-010 xfer_data  output  DATAWIDTH  payload held stable toward the destination; registered.
REQ-011 xfer_ack  input  1  four-phase acknowledge from the destination domain; asynchronous to clk.
REQ-012 busy  output  1  handshake in progress (state != IDLE).
REQ-013 timeout  output  1  sticky timeout flag.

Function
REQ-014 States: IDLE, REQ, RELEASE; the block SHALL be in exactly one at a time.
REQ-015 in_ready = 1 only in IDLE; combinational from state only, never from in_valid.
REQ-016 IDLE and in_valid=1 at edge N: xfer_data <= in_data, xfer_req <= 1, state <= REQ; both outputs change at N+1.
REQ-017 xfer_ack SHALL pass through NSTAGES flops (ack_s) before any use; raw xfer_ack never feeds logic.
REQ-018 REQ and ack_s=1: xfer_req <= 0, state <= RELEASE.
REQ-019 RELEASE and ack_s=0: state <= IDLE; in_ready=1 the following cycle.
REQ-020 xfer_data SHALL change only on the IDLE->REQ transition; it is held through REQ, RELEASE and IDLE.
REQ-021 Minimum cycles per transfer = 2*NSTAGES+2 when ack follows req with zero delay; back-to-back accepts spaced accordingly.
REQ-022 ack_s=1 while in IDLE (stale or spurious ack): ignored; in_valid still accepted, REQ then waits for ack_s to be sampled 1 normally.
REQ-023 ack_s=0 in REQ or ack_s=1 in RELEASE: hold state and outputs indefinitely (subject to REQ-029).

Reset
REQ-024 On reset assertion, without a clock edge: state=IDLE, xfer_req=0, xfer_data=0, all ack_s flops=0, timeout=0, timeout counter=0.
REQ-025 Reset mid-handshake abandons the transfer; on release the block is in IDLE with in_ready=1 on the first clock.
REQ-026 Reset deassertion may be asynchronous to clk; the integrator provides a synchronized deassert.

Configuration
REQ-027 Macro CDC_HS_TX_TIMEOUT_EN SHALL compile the timeout watchdog in or out.
REQ-028 Without the macro: timeout is tied 0, no counter exists, TIMEOUT is unused.
REQ-029 With the macro: the counter clears on every state change and increments each cycle in REQ or RELEASE; when it reaches TIMEOUT-1, timeout <= 1 (sticky until reset); the handshake continues unaffected.

Structure
REQ-030 Shared package cdc_pkg SHALL hold the state enumeration (IDLE=0, REQ=1, RELEASE=2) and a default-stages constant (2).
REQ-031 Sub-module cdc_ack_sync (NSTAGES-deep, async active-high reset, 1 bit) SHALL implement REQ-017.
REQ-032 Counter width SHALL be $clog2(TIMEOUT)+1.

Verification
REQ-033 NSTAGES=2: in_data=0xA5 with in_valid=1 in IDLE -> next cycle xfer_req=1, xfer_data=0xA5, in_ready=0, busy=1.
REQ-034 Ack responder raises xfer_ack one cycle after xfer_req and drops it one cycle after xfer_req falls -> xfer_req falls 2-3 cycles after ack rises; in_ready=1 6 or 7 cycles after accept; xfer_data stays 0xA5 throughout.
REQ-035 in_valid held high with 0x01,0x02,0x03 -> three handshakes; each value is presented once in order with no skips; in_data changes during a handshake do not alter xfer_data.
REQ-036 Assert reset while in REQ -> xfer_req=0, busy=0, xfer_data=0 immediately; one clock after release, in_ready=1.
REQ-037 With CDC_HS_TX_TIMEOUT_EN and TIMEOUT=16, xfer_ack held 0 -> timeout=1 after 16 cycles in REQ and stays 1; a later ack completes the transfer normally.
REQ-038 xfer_ack=1 while IDLE, then in_valid -> xfer_req=1, then xfer_req=0 after the ack sync latency; the block returns to IDLE once ack drops.
